// File: rtl/sd_host_platform_sim_if.sv
// Stack-side port bundle of the host SD PHY (command and data byte streams).
// Handshake: o_sd_data_req, o_sd_data_stb and o_sd_cmd_stb are single-cycle strobes with no
// backpressure; the stack must present i_sd_data_out / i_sd_cmd_out before the next strobe.
interface sd_host_platform_sim_if;
  logic       i_clk_en;
  logic       i_sd_cmd_dir;
  logic       i_sd_cmd_out;
  logic       o_sd_cmd_in;
  logic       o_sd_cmd_stb;
  logic       i_sd_data_dir;
  logic [7:0] i_sd_data_out;
  logic       o_sd_data_req;
  logic [7:0] o_sd_data_in;
  logic       o_sd_data_stb;

  modport slave (
    input  i_clk_en, i_sd_cmd_dir, i_sd_cmd_out, i_sd_data_dir, i_sd_data_out,
    output o_sd_cmd_in, o_sd_cmd_stb, o_sd_data_req, o_sd_data_in, o_sd_data_stb
  );

  modport master (
    output i_clk_en, i_sd_cmd_dir, i_sd_cmd_out, i_sd_data_dir, i_sd_data_out,
    input  o_sd_cmd_in, o_sd_cmd_stb, o_sd_data_req, o_sd_data_in, o_sd_data_stb
  );
endinterface

// File: rtl/sd_host_platform_sim.sv
// Host-side SD PHY: divides clk into the SD clock, serialises cmd bits and DDR data nibbles,
// and reassembles device nibbles into bytes.
module sd_host_platform_sim #(
  parameter int CLK_DIV    = 4,
  parameter int SAMPLE_DLY = 2,
  parameter int LOCK_CNT   = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 o_locked,
  output logic                 o_phy_clk,
  output logic [1:0]           o_dbg_state,
  sd_host_platform_sim_if.slave bus,
  inout  wire                  io_phy_sd_cmd,
  inout  wire  [3:0]           io_phy_sd_data
);
  localparam int CW = $clog2(CLK_DIV);
  localparam int LW = $clog2(LOCK_CNT + 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_HIGH = 2'd1, S_LOW = 2'd2} state_t;

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_div_cnt, w_div_nxt;
  logic          w_div_last, w_rise, w_fall, w_hi_sample, w_lo_sample;
  logic          r_phy_clk;
  logic [LW-1:0] r_lock_cnt;
  logic          r_locked;
  logic          r_cmd_out, r_cmd_in, r_cmd_stb;
  logic [3:0]    r_tx_nib, r_tx_low, r_rx_hi;
  logic          r_data_req, r_data_stb;
  logic [7:0]    r_data_in;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lock_cnt <= '0;
      r_locked   <= 1'b0;
    end else begin
      if (r_lock_cnt != LW'(LOCK_CNT)) r_lock_cnt <= r_lock_cnt + LW'(1);
      if (r_lock_cnt == LW'(LOCK_CNT)) r_locked <= 1'b1;
    end
  end

  // The enable is only looked at when a LOW phase ends, so a period is never truncated.
  always_comb begin
    w_state_nxt = r_state;
    w_div_nxt   = r_div_cnt;
    w_rise      = 1'b0;
    w_fall      = 1'b0;
    w_div_last  = (r_div_cnt == CW'(CLK_DIV - 1));
    case (r_state)
      S_IDLE: begin
        w_div_nxt = '0;
        if (r_locked && bus.i_clk_en) begin
          w_state_nxt = S_HIGH;
          w_rise      = 1'b1;
        end
      end
      S_HIGH: begin
        if (w_div_last) begin
          w_state_nxt = S_LOW;
          w_div_nxt   = '0;
          w_fall      = 1'b1;
        end else begin
          w_div_nxt = r_div_cnt + CW'(1);
        end
      end
      S_LOW: begin
        if (w_div_last) begin
          w_div_nxt = '0;
          if (bus.i_clk_en) begin
            w_state_nxt = S_HIGH;
            w_rise      = 1'b1;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_div_nxt = r_div_cnt + CW'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_div_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_div_cnt <= '0;
      r_phy_clk <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_div_cnt <= w_div_nxt;
      r_phy_clk <= (w_state_nxt == S_HIGH);
    end
  end

  assign w_hi_sample = (r_state == S_HIGH) && (r_div_cnt == CW'(SAMPLE_DLY - 1));
  assign w_lo_sample = (r_state == S_LOW) && w_div_last;

  // Transmit nibbles go out bit-reversed: pin0 carries the most significant bit of each nibble.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cmd_out  <= 1'b0;
      r_cmd_in   <= 1'b0;
      r_cmd_stb  <= 1'b0;
      r_tx_nib   <= 4'h0;
      r_tx_low   <= 4'h0;
      r_data_req <= 1'b0;
      r_rx_hi    <= 4'h0;
      r_data_in  <= 8'h00;
      r_data_stb <= 1'b0;
    end else begin
      r_cmd_stb  <= w_rise;
      r_data_req <= w_rise;
      r_data_stb <= w_lo_sample;
      if (w_fall) begin
        r_cmd_out <= bus.i_sd_cmd_out;
        r_tx_nib  <= r_tx_low;
      end
      if (w_rise) begin
        r_cmd_in <= io_phy_sd_cmd;
        r_tx_nib <= {bus.i_sd_data_out[4], bus.i_sd_data_out[5],
                     bus.i_sd_data_out[6], bus.i_sd_data_out[7]};
        r_tx_low <= {bus.i_sd_data_out[0], bus.i_sd_data_out[1],
                     bus.i_sd_data_out[2], bus.i_sd_data_out[3]};
      end
      if (w_hi_sample) r_rx_hi <= io_phy_sd_data;
      if (w_lo_sample) r_data_in <= {r_rx_hi, io_phy_sd_data};
    end
  end

  assign io_phy_sd_cmd  = bus.i_sd_cmd_dir  ? r_cmd_out : 1'bz;
  assign io_phy_sd_data = bus.i_sd_data_dir ? r_tx_nib  : 4'bzzzz;

  assign o_locked          = r_locked;
  assign o_phy_clk         = r_phy_clk;
  assign o_dbg_state       = r_state;
  assign bus.o_sd_cmd_in   = r_cmd_in;
  assign bus.o_sd_cmd_stb  = r_cmd_stb;
  assign bus.o_sd_data_req = r_data_req;
  assign bus.o_sd_data_in  = r_data_in;
  assign bus.o_sd_data_stb = r_data_stb;
endmodule

// File: tb/tb_sd_host_platform_sim.sv
// Bench for the host SD PHY: the bench plays the SD stack and the device end of the pins,
// predicting pin nibbles, received bytes and clock timing from the bus rules.
module tb_sd_host_platform_sim;
  localparam int CLK_DIV    = 4;
  localparam int SAMPLE_DLY = 2;
  localparam int LOCK_CNT   = 15;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       o_locked, o_phy_clk;
  logic [1:0] dbg_state;
  wire        io_cmd;
  wire  [3:0] io_data;
  logic       dev_cmd_en  = 1'b0;
  logic       dev_cmd     = 1'b0;
  logic       dev_data_en = 1'b0;
  logic [7:0] dev_byte    = 8'h00;
  int         vectors     = 0;
  int         miscompares = 0;

  sd_host_platform_sim_if bus();

  // Device end: high nibble while the SD clock is high, low nibble otherwise.
  assign io_cmd  = dev_cmd_en ? dev_cmd : 1'bz;
  assign io_data = dev_data_en ? (o_phy_clk ? dev_byte[7:4] : dev_byte[3:0]) : 4'bzzzz;

  sd_host_platform_sim #(.CLK_DIV(CLK_DIV), .SAMPLE_DLY(SAMPLE_DLY), .LOCK_CNT(LOCK_CNT)) dut (
    .clk            (clk),
    .rst            (rst),
    .o_locked       (o_locked),
    .o_phy_clk      (o_phy_clk),
    .o_dbg_state    (dbg_state),
    .bus            (bus.slave),
    .io_phy_sd_cmd  (io_cmd),
    .io_phy_sd_data (io_data)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] pin_order(input logic [3:0] nib);
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = nib[3-i];
    return r;
  endfunction

  task automatic wait_req(input string tag, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.o_sd_data_req) begin
        ok = 1'b1;
        break;
      end
    end
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL %s: no data_req within 200 cycles (got 0, need 1)", tag);
    end
  endtask

  task automatic check_relock(input string tag);
    int first = 0;
    int bad   = 0;
    for (int n = 1; n <= 24; n++) begin
      @(negedge clk);
      if (o_locked && first == 0) first = n;
      if (!o_locked && (o_phy_clk || bus.o_sd_data_req || bus.o_sd_data_stb || bus.o_sd_cmd_stb))
        bad++;
    end
    vectors++;
    if (first !== LOCK_CNT + 1) begin
      miscompares++;
      $display("FAIL %s_lock_delay: got %0d cycles, need %0d", tag, first, LOCK_CNT + 1);
    end
    vectors++;
    if (bad !== 0) begin
      miscompares++;
      $display("FAIL %s_activity_unlocked: got %0d active cycles, need 0", tag, bad);
    end
  endtask

  task automatic test_reset();
    bus.i_clk_en      = 1'b1;
    bus.i_sd_cmd_dir  = 1'b0;
    bus.i_sd_cmd_out  = 1'b0;
    bus.i_sd_data_dir = 1'b0;
    bus.i_sd_data_out = 8'h00;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if ({o_locked, o_phy_clk, bus.o_sd_data_req, bus.o_sd_data_stb, bus.o_sd_cmd_stb} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: got %b, need 00000",
               {o_locked, o_phy_clk, bus.o_sd_data_req, bus.o_sd_data_stb, bus.o_sd_cmd_stb});
    end
    vectors++;
    if ({bus.o_sd_cmd_in, bus.o_sd_data_in} !== 9'h000) begin
      miscompares++;
      $display("FAIL reset_data: got %h, need 000", {bus.o_sd_cmd_in, bus.o_sd_data_in});
    end
    rst = 1'b0;
    check_relock("reset");
  endtask

  task automatic test_clock();
    int   runs[$];
    int   cur_run = 0;
    bit   started = 1'b0;
    logic prev    = o_phy_clk;
    logic rise;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      rise = o_phy_clk && !prev;
      vectors++;
      if (bus.o_sd_data_req !== rise || bus.o_sd_cmd_stb !== rise) begin
        miscompares++;
        $display("FAIL clk_strobes: req=%b cmd_stb=%b, need %b", bus.o_sd_data_req, bus.o_sd_cmd_stb, rise);
      end
      if (o_phy_clk != prev) begin
        if (started) runs.push_back(cur_run);
        started = 1'b1;
        cur_run = 1;
      end else begin
        cur_run++;
      end
      prev = o_phy_clk;
    end
    vectors++;
    if (runs.size() < 6) begin
      miscompares++;
      $display("FAIL clk_edges: got %0d half-periods, need >= 6", runs.size());
    end
    foreach (runs[i]) begin
      vectors++;
      if (runs[i] !== CLK_DIV) begin
        miscompares++;
        $display("FAIL clk_half_period: got %0d cycles, need %0d", runs[i], CLK_DIV);
      end
    end
  endtask

  task automatic test_data_tx();
    logic [7:0] seq[$];
    logic [7:0] cur, pending;
    logic [3:0] exp;
    int         n;
    bit         ok;
    seq.push_back(8'hA5);
    seq.push_back(8'h3C);
    repeat (6) seq.push_back(8'($urandom_range(0, 255)));
    bus.i_sd_data_dir = 1'b1;
    pending = seq[0];
    bus.i_sd_data_out = pending;
    wait_req("tx_sync", ok);
    if (!ok) return;
    cur = pending;
    n = 1;
    pending = seq[1];
    bus.i_sd_data_out = pending;
    for (int c = 0; c < 400; c++) begin
      if (c != 0) @(negedge clk);
      if (c != 0 && bus.o_sd_data_req) begin
        if (n == seq.size()) break;
        cur = pending;
        n++;
        pending = (n < seq.size()) ? seq[n] : 8'h00;
        bus.i_sd_data_out = pending;
      end
      exp = o_phy_clk ? pin_order(cur[7:4]) : pin_order(cur[3:0]);
      vectors++;
      if (io_data !== exp) begin
        miscompares++;
        $display("FAIL tx_pins: byte %h clk=%b got %b, need %b", cur, o_phy_clk, io_data, exp);
      end
      if (cur == 8'hA5 || cur == 8'h3C) begin
        vectors++;
        if (cur == 8'hA5 && io_data !== (o_phy_clk ? 4'b0101 : 4'b1010)) begin
          miscompares++;
          $display("FAIL tx_a5: clk=%b got %b", o_phy_clk, io_data);
        end
        if (cur == 8'h3C && io_data !== (o_phy_clk ? 4'b1100 : 4'b0011)) begin
          miscompares++;
          $display("FAIL tx_3c: clk=%b got %b", o_phy_clk, io_data);
        end
      end
    end
    vectors++;
    if (n !== seq.size()) begin
      miscompares++;
      $display("FAIL tx_bytes: got %0d captured, need %0d", n, seq.size());
    end
    bus.i_sd_data_dir = 1'b0;
  endtask

  task automatic test_data_rx();
    logic [7:0] seq[$];
    logic [7:0] exp_q[$];
    logic [7:0] e;
    int         k, got;
    bit         ok;
    seq.push_back(8'h96);
    repeat (6) seq.push_back(8'($urandom_range(0, 255)));
    seq.push_back(8'h5A);
    bus.i_sd_data_dir = 1'b0;
    dev_data_en = 1'b1;
    wait_req("rx_sync", ok);
    if (!ok) begin
      dev_data_en = 1'b0;
      return;
    end
    dev_byte = seq[0];
    exp_q.push_back(seq[0]);
    k = 1;
    got = 0;
    for (int c = 0; c < 400 && got < seq.size(); c++) begin
      @(negedge clk);
      if (bus.o_sd_data_stb) begin
        vectors++;
        got++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL rx_spurious_stb: data_in=%h, need no strobe", bus.o_sd_data_in);
        end else begin
          e = exp_q.pop_front();
          if (bus.o_sd_data_in !== e) begin
            miscompares++;
            $display("FAIL rx_byte: got %h, need %h", bus.o_sd_data_in, e);
          end
        end
      end
      if (bus.o_sd_data_req && k < seq.size()) begin
        dev_byte = seq[k];
        exp_q.push_back(seq[k]);
        k++;
      end
    end
    vectors++;
    if (got !== seq.size() || exp_q.size() !== 0) begin
      miscompares++;
      $display("FAIL rx_count: got %0d strobes, need %0d", got, seq.size());
    end
    dev_data_en = 1'b0;
  endtask

  task automatic test_cmd();
    logic bits[$];
    logic exp_q[$];
    logic e, prev_clk, prev_pin, fall;
    int   tx, got;
    bit   ok;
    bits.push_back(1'b1);
    bits.push_back(1'b0);
    bits.push_back(1'b1);
    bits.push_back(1'b1);
    repeat (3) bits.push_back(1'($urandom_range(0, 1)));
    bits.push_back(1'b1);
    bus.i_sd_cmd_dir = 1'b1;
    wait_req("cmd_sync", ok);
    if (!ok) return;
    bus.i_sd_cmd_out = bits[0];
    tx = 0;
    got = 0;
    prev_clk = o_phy_clk;
    prev_pin = io_cmd;
    for (int c = 0; c < 400 && got < bits.size(); c++) begin
      @(negedge clk);
      fall = prev_clk && !o_phy_clk;
      vectors++;
      if (io_cmd !== prev_pin && !fall) begin
        miscompares++;
        $display("FAIL cmd_pin_change: pin %b -> %b off a fall edge, need stable", prev_pin, io_cmd);
      end
      if (fall && tx < bits.size()) begin
        exp_q.push_back(bits[tx]);
        vectors++;
        if (io_cmd !== bits[tx]) begin
          miscompares++;
          $display("FAIL cmd_pin: got %b, need %b", io_cmd, bits[tx]);
        end
        tx++;
        bus.i_sd_cmd_out = (tx < bits.size()) ? bits[tx] : 1'b1;
      end
      if (bus.o_sd_cmd_stb) begin
        vectors++;
        got++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL cmd_spurious_stb: cmd_in=%b, need no strobe", bus.o_sd_cmd_in);
        end else begin
          e = exp_q.pop_front();
          if (bus.o_sd_cmd_in !== e) begin
            miscompares++;
            $display("FAIL cmd_loopback: got %b, need %b", bus.o_sd_cmd_in, e);
          end
        end
      end
      prev_clk = o_phy_clk;
      prev_pin = io_cmd;
    end
    vectors++;
    if (got !== bits.size()) begin
      miscompares++;
      $display("FAIL cmd_count: got %0d strobes, need %0d", got, bits.size());
    end
  endtask

  task automatic test_clk_en();
    int   high = 0, rises = 0, reqs = 0, late_stb = 0, low_run = 0, run = 0;
    logic prev;
    bit   ok;
    wait_req("clken_sync", ok);
    if (!ok) return;
    @(negedge clk);
    bus.i_clk_en = 1'b0;
    prev = o_phy_clk;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (o_phy_clk) high++;
      if (o_phy_clk && !prev) rises++;
      if (bus.o_sd_data_req) reqs++;
      low_run = o_phy_clk ? 0 : low_run + 1;
      if (low_run >= CLK_DIV + 2 && bus.o_sd_data_stb) late_stb++;
      prev = o_phy_clk;
    end
    vectors++;
    if (high !== CLK_DIV - 2) begin
      miscompares++;
      $display("FAIL clken_finish_high: got %0d high cycles, need %0d", high, CLK_DIV - 2);
    end
    vectors++;
    if (rises !== 0 || reqs !== 0 || late_stb !== 0) begin
      miscompares++;
      $display("FAIL clken_idle: rises=%0d reqs=%0d stbs=%0d, need 0/0/0", rises, reqs, late_stb);
    end
    bus.i_clk_en = 1'b1;
    wait_req("clken_restart", ok);
    if (!ok) return;
    for (int i = 0; i < 20; i++) begin
      if (!o_phy_clk) break;
      run++;
      @(negedge clk);
    end
    vectors++;
    if (run !== CLK_DIV) begin
      miscompares++;
      $display("FAIL clken_restart_high: got %0d cycles, need %0d", run, CLK_DIV);
    end
    // Now in the first LOW cycle; drop the enable on the last one.
    repeat (CLK_DIV - 1) @(negedge clk);
    bus.i_clk_en = 1'b0;
    high = 0;
    reqs = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (o_phy_clk) high++;
      if (bus.o_sd_data_req) reqs++;
    end
    vectors++;
    if (high !== 0 || reqs !== 0) begin
      miscompares++;
      $display("FAIL clken_last_low: high=%0d reqs=%0d, need 0/0", high, reqs);
    end
    bus.i_clk_en = 1'b1;
  endtask

  task automatic test_reset_mid();
    logic [7:0] b;
    bit         ok;
    bus.i_sd_data_dir = 1'b1;
    bus.i_sd_cmd_dir  = 1'b1;
    bus.i_sd_cmd_out  = 1'b1;
    bus.i_sd_data_out = 8'hC3;
    wait_req("rstmid_sync0", ok);
    if (!ok) return;
    wait_req("rstmid_sync1", ok);
    if (!ok) return;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if ({o_locked, o_phy_clk, bus.o_sd_cmd_in, bus.o_sd_cmd_stb, bus.o_sd_data_req, bus.o_sd_data_stb} !== 6'b0) begin
      miscompares++;
      $display("FAIL rstmid_ctrl: got %b, need 000000",
               {o_locked, o_phy_clk, bus.o_sd_cmd_in, bus.o_sd_cmd_stb, bus.o_sd_data_req, bus.o_sd_data_stb});
    end
    vectors++;
    if (bus.o_sd_data_in !== 8'h00) begin
      miscompares++;
      $display("FAIL rstmid_data_in: got %h, need 00", bus.o_sd_data_in);
    end
    vectors++;
    if (io_data !== 4'h0 || io_cmd !== 1'b0) begin
      miscompares++;
      $display("FAIL rstmid_tx_regs: data=%b cmd=%b, need 0000/0", io_data, io_cmd);
    end
    bus.i_sd_data_dir = 1'b0;
    bus.i_sd_cmd_dir  = 1'b0;
    b = 8'($urandom_range(0, 255));
    dev_byte    = b;
    dev_data_en = 1'b1;
    dev_cmd     = 1'b1;
    dev_cmd_en  = 1'b1;
    #1;
    vectors++;
    if (io_data !== b[3:0] || io_cmd !== 1'b1) begin
      miscompares++;
      $display("FAIL rstmid_release_pins: data=%b cmd=%b, need %b/1", io_data, io_cmd, b[3:0]);
    end
    dev_data_en = 1'b0;
    dev_cmd_en  = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check_relock("rstmid");
  endtask

  initial begin
    test_reset();
    test_clock();
    test_data_tx();
    test_data_rx();
    test_cmd();
    test_clk_en();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
